// File: rtl/coin_pulse_gen_pkg.sv
// Shared coin front-end definitions: debounce state encodings, the default
// debounce window, and the coin codes also used by the vending FSM.
package coin_pkg;

  // One-hot debounce states; any other encoding is treated as illegal.
  typedef enum logic [3:0] {
    ST_IDLE        = 4'b0001,
    ST_FILTER_DOWN = 4'b0010,
    ST_DOWN        = 4'b0100,
    ST_FILTER_UP   = 4'b1000
  } db_state_e;

  // 20 ms at 50 MHz.
  localparam int unsigned CNT_MAX_DEF = 20'd999_999;
  localparam int          CNT_W_DEF   = 20;

  // Coin codes as seen by the vending FSM.
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;

endpackage

// File: rtl/coin_pulse_gen_if.sv
// Coin slot bundle: raw active-low switches in, accepted-coin pulses out.
interface coin_pulse_gen_if;
  logic key_one_n;
  logic key_half_n;
  logic po_money_one;
  logic po_money_half;

  modport master (
    output key_one_n, key_half_n,
    input  po_money_one, po_money_half
  );

  modport slave (
    input  key_one_n, key_half_n,
    output po_money_one, po_money_half
  );
endinterface

// File: rtl/coin_pulse_gen_debounce.sv
// One channel: 2-flop synchroniser, debounce counter and one-hot FSM.
// press is a registered one-cycle strobe on each accepted key-down.
module key_debounce
  import coin_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEF,
  parameter int          CNT_W   = CNT_W_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [1:0]       sync;
  db_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt;
  logic             key_s;
  logic             cnt_done;

  assign key_s    = sync[1];
  assign cnt_done = (cnt == CNT_LAST);

  // Synchroniser; resets to released so reset never looks like a press.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) sync <= 2'b11;
    else            sync <= {sync[0], key_n};
  end

  // State, counter and strobe registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
    end
  end

  // Next state; the counter only advances while staying in a filter state,
  // so it clears on every transition and stops at CNT_LAST (no wrap).
  always_comb begin
    state_nxt = ST_IDLE;
    cnt_nxt   = '0;
    case (state)
      ST_IDLE:
        state_nxt = key_s ? ST_IDLE : ST_FILTER_DOWN;
      ST_FILTER_DOWN:
        if (key_s)         state_nxt = ST_IDLE;
        else if (cnt_done) state_nxt = ST_DOWN;
        else begin
          state_nxt = ST_FILTER_DOWN;
          cnt_nxt   = cnt + 1'b1;
        end
      ST_DOWN:
        state_nxt = key_s ? ST_FILTER_UP : ST_DOWN;
      ST_FILTER_UP:
        if (!key_s)        state_nxt = ST_DOWN;
        else if (cnt_done) state_nxt = ST_IDLE;
        else begin
          state_nxt = ST_FILTER_UP;
          cnt_nxt   = cnt + 1'b1;
        end
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Strobe only on the FILTER_DOWN -> DOWN transition; release is silent.
  always_comb begin
    press_nxt = (state == ST_FILTER_DOWN) && !key_s && cnt_done;
  end

endmodule

// File: rtl/coin_pulse_gen.sv
// Coin front end: debounces both slots and emits one registered pulse per
// accepted coin, never both in the same cycle.
module coin_pulse_gen
  import coin_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEF,
  parameter int          CNT_W   = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  coin_pulse_gen_if.slave  bus
);

  logic press_one, press_half;
  logic half_pend;
  logic money_one_q, money_half_q;

  key_debounce #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) u_db_one (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_n    (bus.key_one_n),
    .press    (press_one)
  );

  key_debounce #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) u_db_half (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_n    (bus.key_half_n),
    .press    (press_half)
  );

  // Arbiter: one-yuan wins a tie; the half-yuan pulse is held one cycle in
  // half_pend and re-deferred if another one-yuan pulse lands on it.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      money_one_q  <= 1'b0;
      money_half_q <= 1'b0;
      half_pend    <= 1'b0;
    end else begin
      money_one_q  <= press_one;
      money_half_q <= (press_half | half_pend) & ~press_one;
      half_pend    <= (press_half | half_pend) & press_one;
    end
  end

  assign bus.po_money_one  = money_one_q;
  assign bus.po_money_half = money_half_q;

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Directed bench for coin_pulse_gen with CNT_MAX = 4. Cycle k is the period
// after rising edge k; inputs for edge k are driven before it, outputs are
// sampled 1 ns after it.
module tb_coin_pulse_gen;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  coin_pulse_gen_if bus ();

  coin_pulse_gen #(.CNT_MAX(4), .CNT_W(3)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs for the next edge, then wait past it.
  task automatic step(input logic one_n, input logic half_n,
                      input logic rst_n);
    bus.key_one_n  = one_n;
    bus.key_half_n = half_n;
    sys_rst_n      = rst_n;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk($sformatf("%s_rst_one%0d", tag, i), bus.po_money_one, 0);
      chk($sformatf("%s_rst_half%0d", tag, i), bus.po_money_half, 0);
    end
    step(1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    int   pulses;
    logic kn;
    bus.key_one_n  = 1'b1;
    bus.key_half_n = 1'b1;
    @(negedge sys_clk);

    // 1: clean press, pulse in cycle 7 only.
    do_reset("t1");
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 1'b1);
      chk($sformatf("t1_one_c%0d", k), bus.po_money_one, (k == 7));
      chk($sformatf("t1_half_c%0d", k), bus.po_money_half, 0);
    end

    // 2: half key bounces 2/2 for 12 cycles then stays low from cycle 12.
    do_reset("t2");
    for (int k = 0; k < 30; k++) begin
      kn = (k < 12) ? logic'((k >> 1) & 1) : 1'b0;
      step(1'b1, kn, 1'b1);
      chk($sformatf("t2_half_c%0d", k), bus.po_money_half, (k == 19));
      chk($sformatf("t2_one_c%0d", k), bus.po_money_one, 0);
    end

    // 3: simultaneous press, one-yuan at 7, half-yuan deferred to 8.
    do_reset("t3");
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 1'b1);
      chk($sformatf("t3_one_c%0d", k), bus.po_money_one, (k == 7));
      chk($sformatf("t3_half_c%0d", k), bus.po_money_half, (k == 8));
      chk($sformatf("t3_ovl_c%0d", k),
          bus.po_money_one & bus.po_money_half, 0);
    end

    // 4: 100-cycle hold, then release with 2-cycle low glitches.
    do_reset("t4");
    pulses = 0;
    for (int k = 0; k < 140; k++) begin
      if (k < 100)      kn = 1'b0;
      else if (k < 108) kn = ~logic'(((k - 100) >> 1) & 1);
      else              kn = 1'b1;
      step(kn, 1'b1, 1'b1);
      pulses += int'(bus.po_money_one);
      chk($sformatf("t4_one_c%0d", k), bus.po_money_one, (k == 7));
      chk($sformatf("t4_half_c%0d", k), bus.po_money_half, 0);
    end
    chk("t4_pulse_count", pulses, 1);

    // 5: reset during cycles 3-4 discards the partial press.
    do_reset("t5");
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, !(k == 3 || k == 4));
      chk($sformatf("t5_one_c%0d", k), bus.po_money_one, (k == 12));
      chk($sformatf("t5_half_c%0d", k), bus.po_money_half, 0);
    end

    // 6: two presses separated by exactly 10 release cycles.
    do_reset("t6");
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      kn = (k >= 10 && k < 20);
      step(kn, 1'b1, 1'b1);
      pulses += int'(bus.po_money_one);
      chk($sformatf("t6_one_c%0d", k), bus.po_money_one,
          (k == 7 || k == 27));
      chk($sformatf("t6_half_c%0d", k), bus.po_money_half, 0);
    end
    chk("t6_pulse_count", pulses, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
